// File: rtl/sw_ctrl_pkg.sv
// Shared definitions for the slide-switch debounce controller:
// register map, edge-mode encodings and the block FSM states.
package sw_ctrl_pkg;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_EDGE = 2'd1;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_CTRL = 2'd3;

    localparam int CTRL_INIT_DONE_BIT = 8;

    typedef enum logic [1:0] {
        EDGE_RISE = 2'b00,
        EDGE_FALL = 2'b01,
        EDGE_BOTH = 2'b10,
        EDGE_NONE = 2'b11
    } edge_mode_t;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } ctrl_state_t;

    // old_level is the debounced value before the accepted change
    function automatic logic edge_qualify(input edge_mode_t mode,
                                          input logic       change,
                                          input logic       old_level);
        logic hit;
        hit = 1'b0;
        case (mode)
            EDGE_RISE: hit = change & ~old_level;
            EDGE_FALL: hit = change & old_level;
            EDGE_BOTH: hit = change;
            default:   hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/sw_debounce_bit.sv
// One switch lane: 2-flop synchroniser, tick-driven stability counter and
// debounced level, with a combinational pulse on the cycle a change is accepted.
module sw_debounce_bit #(
    parameter int STABLE_TICKS = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic tick,
    input  logic raw,
    output logic debounced,
    output logic change
);

    localparam logic [3:0] ACCEPT_CNT = 4'(STABLE_TICKS - 1);

    logic       sync1_reg;
    logic       sync2_reg;
    logic       deb_reg;
    logic       deb_next;
    logic [3:0] cnt_reg;
    logic [3:0] cnt_next;

    // Acceptance happens on the tick that would bring cnt to STABLE_TICKS,
    // so cnt itself never holds that value.
    always_comb begin
        cnt_next = cnt_reg;
        deb_next = deb_reg;
        change   = 1'b0;
        if (tick) begin
            if (sync2_reg == deb_reg) begin
                cnt_next = '0;
            end else if (cnt_reg == ACCEPT_CNT) begin
                deb_next = sync2_reg;
                cnt_next = '0;
                change   = 1'b1;
            end else begin
                cnt_next = cnt_reg + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            deb_reg   <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            sync1_reg <= raw;
            sync2_reg <= sync1_reg;
            deb_reg   <= deb_next;
            cnt_reg   <= cnt_next;
        end
    end

    assign debounced = deb_reg;

endmodule

// File: rtl/sw_debounce_ctrl.sv
// Avalon-MM slave for the slide-switch bank: shared tick prescaler, INIT/RUN
// sequencing, DATA/EDGE/MASK/CTRL registers, registered read mux and irq.
module sw_debounce_ctrl
    import sw_ctrl_pkg::*;
#(
    parameter int WIDTH        = 10,
    parameter int TICK_DIV     = 50000,
    parameter int STABLE_TICKS = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             read,
    input  logic             write,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam int PRESC_W = $clog2(TICK_DIV);

    logic [PRESC_W-1:0] presc_reg;
    logic               tick;

    ctrl_state_t        state_reg;
    logic [3:0]         init_cnt_reg;
    logic               init_done_reg;

    logic [WIDTH-1:0]   data_level;
    logic [WIDTH-1:0]   bit_change;
    logic [WIDTH-1:0]   edge_set;
    logic [WIDTH-1:0]   edge_reg;
    logic [WIDTH-1:0]   edge_next;
    logic [WIDTH-1:0]   mask_reg;
    edge_mode_t         edge_mode_reg;

    logic               wr_en;
    logic [31:0]        rd_mux;

    // Reads are served every cycle from address alone; the strobe and the
    // high write-data bits carry no extra information here.
    logic               unused_inputs;
    assign unused_inputs = ^{read, writedata};

    assign tick  = (presc_reg == PRESC_W'(TICK_DIV - 1));
    assign wr_en = chipselect & write;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_reg <= '0;
        end else if (tick) begin
            presc_reg <= '0;
        end else begin
            presc_reg <= presc_reg + PRESC_W'(1);
        end
    end

    // INIT outlasts the first possible acceptance by one tick, so levels
    // present at power-up settle into DATA without raising EDGE bits.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= INIT;
            init_cnt_reg  <= '0;
            init_done_reg <= 1'b0;
        end else begin
            case (state_reg)
                INIT: begin
                    if (tick) begin
                        if (init_cnt_reg == 4'(STABLE_TICKS)) begin
                            state_reg     <= RUN;
                            init_done_reg <= 1'b1;
                        end else begin
                            init_cnt_reg <= init_cnt_reg + 4'd1;
                        end
                    end
                end
                default: state_reg <= RUN;
            endcase
        end
    end

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bits
        sw_debounce_bit #(
            .STABLE_TICKS(STABLE_TICKS)
        ) u_bit (
            .clk       (clk),
            .reset_n   (reset_n),
            .tick      (tick),
            .raw       (in_port[gi]),
            .debounced (data_level[gi]),
            .change    (bit_change[gi])
        );

        assign edge_set[gi] = (state_reg == RUN) &&
                              edge_qualify(edge_mode_reg, bit_change[gi], data_level[gi]);
    end

    // A new event is OR-ed in after the clear so it survives a same-cycle W1C.
    always_comb begin
        edge_next = edge_reg | edge_set;
        if (wr_en && (address == ADDR_EDGE)) begin
            edge_next = (edge_reg & ~writedata[WIDTH-1:0]) | edge_set;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_DATA: rd_mux = 32'(data_level);
            ADDR_EDGE: rd_mux = 32'(edge_reg);
            ADDR_MASK: rd_mux = 32'(mask_reg);
            ADDR_CTRL: begin
                rd_mux[1:0]                = edge_mode_reg;
                rd_mux[CTRL_INIT_DONE_BIT] = init_done_reg;
            end
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_reg      <= '0;
            mask_reg      <= '0;
            edge_mode_reg <= EDGE_RISE;
            readdata      <= '0;
            irq           <= 1'b0;
        end else begin
            edge_reg <= edge_next;
            if (wr_en && (address == ADDR_MASK)) begin
                mask_reg <= writedata[WIDTH-1:0];
            end
            if (wr_en && (address == ADDR_CTRL)) begin
                edge_mode_reg <= edge_mode_t'(writedata[1:0]);
            end
            readdata <= chipselect ? rd_mux : 32'd0;
            irq      <= |(edge_reg & mask_reg);
        end
    end

endmodule

// File: doc/sw_debounce_ctrl.md
# sw_debounce_ctrl

Avalon-MM slave controller for the DE1-SoC slide-switch bank, the sequencing layer between raw `in_port` switches and the HPS. It synchronises and debounces each switch, records edges in a write-1-to-clear capture register, and raises a maskable interrupt. Software reads clean switch state and edge events without polling raw, bouncing inputs.

## Interface
- `WIDTH`, 10: number of switch inputs (1..32).
- `TICK_DIV`, 50000: clk cycles per debounce sample tick (≥2); 1 ms at 50 MHz.
- `STABLE_TICKS`, 4: consecutive mismatching ticks before a switch change is accepted (1..15).
- `clk`  in  1  system clock.
- `reset_n`  in  1  reset: one clock, asynchronous and active-low.
- `address`  in  2  register select.
- `chipselect`  in  1  slave select; qualifies `read` and `write`.
- `read`  in  1  read strobe.
- `write`  in  1  write strobe.
- `writedata`  in  32  write data.
- `readdata`  out  32  registered read data.
- `in_port`  in  WIDTH  raw asynchronous switch inputs.
- `irq`  out  1  level interrupt, active-high.

## Operation
- Register map:
  - 0 DATA: RO, debounced state `[WIDTH-1:0]`.
  - 1 EDGE: captured edges; write 1 clears the bit.
  - 2 MASK: RW, per-bit irq enable.
  - 3 CTRL: RW; `[1:0]` edge mode (00 rising, 01 falling, 10 both, 11 none); `[8]` RO init-done.
- Unused high bits read 0; writes to DATA are ignored.
- Each input passes through a 2-flop synchroniser.
- A shared prescaler counts 0..TICK_DIV-1 and pulses `tick` for one cycle on wrap.
- Per-bit counter `cnt`, 4 bits:
  - On `tick`: if sync ≠ debounced, `cnt`+1; else `cnt` is cleared.
  - When `cnt` reaches STABLE_TICKS, debounced ← sync and `cnt` clears.
  - A bounce back to the old value before acceptance clears `cnt`, so no change is accepted.
- Block FSM:
  - INIT: entered from reset; debounced tracks sync as normal, but edges are never captured. Leaves after STABLE_TICKS+1 ticks.
  - RUN: normal capture. Stays until reset.
  - Effect: switches already high at power-up produce no spurious EDGE bits.
- Edge capture (RUN only):
  - The accepted change event is qualified by CTRL mode and sets the EDGE bit.
  - If a set and a W1C clear of the same bit occur in the same cycle, the set wins.
- `irq` = registered OR of (EDGE & MASK).
- Reset values: readdata 0, irq 0, DATA 0, EDGE 0, MASK 0, CTRL 0 (rising), FSM INIT, prescaler 0, all `cnt` 0, synchronisers 0.
- A reset mid-debounce discards any pending change.

## Timing
- Read latency is 1 cycle.
- `readdata` updates on every clock with the mux output for `address`, and is 0 when `chipselect` is low.
- Writes take effect on the clock edge where `chipselect & write` is high.
- An EDGE W1C write drops `irq` 1 cycle later, unless another bit keeps it asserted.
- `in_port` change to DATA update: 2 sync cycles, plus the wait for the next tick, plus STABLE_TICKS tick periods.
  - Worst case: 2 + STABLE_TICKS·TICK_DIV + 1 cycles.
- DATA update to EDGE set: same cycle (both registered from one event).
- EDGE set to `irq` high: +1 cycle.
- Mode changes apply to the next accepted event; existing EDGE bits are unaffected.

## Structure
- Shared package `sw_ctrl_pkg`:
  - Register address constants: ADDR_DATA, ADDR_EDGE, ADDR_MASK, ADDR_CTRL.
  - Edge-mode encodings.
  - FSM state enum {INIT, RUN}.
- One sub-module, `sw_debounce_bit`: synchroniser, `cnt`, and debounced flop.
  - Inputs: `tick` and raw bit.
  - Outputs: debounced level and one-cycle `change` pulse.
  - Instantiated WIDTH times.
- The top level holds the prescaler, FSM, registers, read mux and irq.

## Test plan
All scenarios use TICK_DIV=4, STABLE_TICKS=3, WIDTH=10.
- Reset with `in_port`=10'h3FF, no bouncing:
  - DATA reads 0x3FF after init; EDGE reads 0; `irq` stays 0.
  - CTRL[8] reads 1 after STABLE_TICKS+1 ticks.
- In RUN, MASK=0x001, bit0 rises cleanly:
  - DATA[0]=1 within 2+12+1 cycles; EDGE=0x001.
  - `irq`=1 one cycle later.
  - Write EDGE=0x001: `irq`=0 the next cycle.
- Bit1 toggles 1→0→1 within 2 ticks:
  - DATA, EDGE and `irq` never change.
  - `cnt` returns to 0.
- CTRL mode=01 (falling) with bit2 rising then falling:
  - Only the fall sets EDGE[2].
  - With mode=11 (none), no EDGE bits are set.
- W1C of EDGE[3] in the same cycle as a new accepted edge on bit3: EDGE[3] remains 1.
- Assert `reset_n` low mid-debounce (bit4 `cnt`=2):
  - All outputs and registers return to 0 asynchronously.
  - After release, a re-debounce occurs in INIT and no EDGE bit is set.
